// File: rtl/core_boot_loader_pkg.sv
// Shared constants and types for the s_core boot loader.
// Macro CORE_BOOT_LOADER_CHECKSUM_EN adds the trailing checksum state.
package core_boot_loader_pkg;

    localparam logic [7:0] BL_CMD_LOAD = 8'hA5;
    localparam logic [7:0] BL_CMD_REG  = 8'h5A;
    localparam logic [7:0] BL_CMD_RUN  = 8'hC3;
    localparam logic [7:0] BL_CMD_HALT = 8'hFF;

    localparam int ERR_CMD     = 0;
    localparam int ERR_TIMEOUT = 1;
    localparam int ERR_CSUM    = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_L_ADDR,
        ST_L_CNT,
        ST_L_DATA,
        ST_WRITE,
        ST_R_IDX,
        ST_R_DATA,
        ST_G_ADDR,
`ifdef CORE_BOOT_LOADER_CHECKSUM_EN
        ST_CHK,
`endif
        ST_RUNNING
    } bl_state_t;

`ifdef CORE_BOOT_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {
        K_LOAD,
        K_REG,
        K_RUN
    } bl_kind_t;
`endif

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/core_boot_loader_word.sv
// Little-endian byte-to-word assembler for the boot loader.
// done flags the 4th byte; word already includes the current byte.
module bl_word_assembler
    import core_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  idx,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        done
);

    logic [23:0] sh;

    assign word = {byte_in, sh};
    assign done = en && (idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            sh <= '0;
        end else if (en) begin
            sh <= word[31:8];
        end
    end

endmodule

// File: rtl/core_boot_loader.sv
// Host-link boot loader: LOAD/REG/RUN/HALT command decoder for s_core setup.
// Define CORE_BOOT_LOADER_CHECKSUM_EN for trailing-checksum commands.
module core_boot_loader
    import core_boot_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic [31:0] o_inst_mem_addr,
    output logic [31:0] o_inst_mem_data,
    output logic        o_inst_we,
    output logic [4:0]  o_load_reg_addr,
    output logic [31:0] o_load_reg_data,
    output logic        o_reg_we,
    output logic        o_setup,
    output logic [31:0] o_start_addr,
    output logic        o_start,
    output logic [2:0]  o_err
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    bl_state_t         state;
    logic [1:0]        bcnt;
    logic [31:0]       addr;
    logic [CNT_W-1:0]  cnt;
    logic [4:0]        ridx;
    logic [31:0]       tcnt;
    logic              accept;
    logic              to_armed;
    logic              to_hit;
    logic [31:0]       asm_word;
    logic              asm_done;

`ifdef CORE_BOOT_LOADER_CHECKSUM_EN
    logic [7:0]        sum;
    logic [7:0]        sum_next;
    bl_kind_t          kind;
    logic              img_bad;
    logic [31:0]       rdata;

    assign sum_next = sum + i_byte;
`endif

    assign accept = i_byte_valid && o_byte_ready;

    always_comb begin
        to_armed = (TIMEOUT_CYCLES != 0) &&
                   (state != ST_IDLE) &&
                   (state != ST_WRITE) &&
                   (state != ST_RUNNING);
        to_hit   = to_armed && !accept && (tcnt == TO_LAST);
    end

    bl_word_assembler u_asm (
        .clk     (clk),
        .rst     (rst),
        .en      (accept),
        .idx     (bcnt),
        .byte_in (i_byte),
        .word    (asm_word),
        .done    (asm_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            bcnt            <= '0;
            addr            <= '0;
            cnt             <= '0;
            ridx            <= '0;
            tcnt            <= '0;
            o_byte_ready    <= 1'b1;
            o_inst_mem_addr <= '0;
            o_inst_mem_data <= '0;
            o_inst_we       <= 1'b0;
            o_load_reg_addr <= '0;
            o_load_reg_data <= '0;
            o_reg_we        <= 1'b0;
            o_setup         <= 1'b1;
            o_start_addr    <= '0;
            o_start         <= 1'b0;
            o_err           <= '0;
`ifdef CORE_BOOT_LOADER_CHECKSUM_EN
            sum             <= '0;
            kind            <= K_LOAD;
            img_bad         <= 1'b0;
            rdata           <= '0;
`endif
        end else begin
            o_inst_we    <= 1'b0;
            o_reg_we     <= 1'b0;
            o_start      <= 1'b0;
            o_byte_ready <= 1'b1;

            if (!to_armed || accept) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 32'd1;
            end

            if (accept) begin
                bcnt <= bcnt + 2'd1;
`ifdef CORE_BOOT_LOADER_CHECKSUM_EN
                sum  <= (state == ST_IDLE) ? i_byte : sum_next;
`endif
            end

            if (to_hit) begin
                // partial command dropped; words already written stay written
                state              <= ST_IDLE;
                bcnt               <= '0;
                o_err[ERR_TIMEOUT] <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            bcnt <= '0;
                            unique case (1'b1)
                                i_byte == BL_CMD_LOAD: state <= ST_L_ADDR;
                                i_byte == BL_CMD_REG:  state <= ST_R_IDX;
                                i_byte == BL_CMD_RUN:  state <= ST_G_ADDR;
                                default: o_err[ERR_CMD] <= 1'b1;
                            endcase
                        end
                    end
                    ST_L_ADDR: begin
                        if (asm_done) begin
                            addr  <= word_align(asm_word);
                            bcnt  <= '0;
                            state <= ST_L_CNT;
                        end
                    end
                    ST_L_CNT: begin
                        if (accept && bcnt == 2'd1) begin
                            cnt  <= asm_word[31:16];
                            bcnt <= '0;
                            if (asm_word[31:16] == '0) begin
`ifdef CORE_BOOT_LOADER_CHECKSUM_EN
                                kind  <= K_LOAD;
                                state <= ST_CHK;
`else
                                state <= ST_IDLE;
`endif
                            end else begin
                                state <= ST_L_DATA;
                            end
                        end
                    end
                    ST_L_DATA: begin
                        if (asm_done) begin
                            o_inst_we       <= 1'b1;
                            o_inst_mem_addr <= addr;
                            o_inst_mem_data <= asm_word;
                            o_byte_ready    <= 1'b0;
                            bcnt            <= '0;
                            state           <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        addr <= addr + 32'd4;
                        cnt  <= cnt - CNT_W'(1);
                        bcnt <= '0;
                        if (cnt == CNT_W'(1)) begin
`ifdef CORE_BOOT_LOADER_CHECKSUM_EN
                            kind  <= K_LOAD;
                            state <= ST_CHK;
`else
                            state <= ST_IDLE;
`endif
                        end else begin
                            state <= ST_L_DATA;
                        end
                    end
                    ST_R_IDX: begin
                        if (accept) begin
                            ridx  <= i_byte[4:0];
                            bcnt  <= '0;
                            state <= ST_R_DATA;
                        end
                    end
                    ST_R_DATA: begin
                        if (asm_done) begin
                            bcnt <= '0;
`ifdef CORE_BOOT_LOADER_CHECKSUM_EN
                            rdata <= asm_word;
                            kind  <= K_REG;
                            state <= ST_CHK;
`else
                            o_reg_we        <= 1'b1;
                            o_load_reg_addr <= ridx;
                            o_load_reg_data <= asm_word;
                            state           <= ST_IDLE;
`endif
                        end
                    end
                    ST_G_ADDR: begin
                        if (asm_done) begin
                            bcnt <= '0;
`ifdef CORE_BOOT_LOADER_CHECKSUM_EN
                            addr  <= word_align(asm_word);
                            kind  <= K_RUN;
                            state <= ST_CHK;
`else
                            o_start      <= 1'b1;
                            o_setup      <= 1'b0;
                            o_start_addr <= word_align(asm_word);
                            state        <= ST_RUNNING;
`endif
                        end
                    end
`ifdef CORE_BOOT_LOADER_CHECKSUM_EN
                    ST_CHK: begin
                        if (accept) begin
                            bcnt  <= '0;
                            state <= ST_IDLE;
                            if (sum_next == 8'h00) begin
                                unique case (kind)
                                    K_LOAD: img_bad <= 1'b0;
                                    K_REG: begin
                                        o_reg_we        <= 1'b1;
                                        o_load_reg_addr <= ridx;
                                        o_load_reg_data <= rdata;
                                    end
                                    default: begin
                                        // a failed image must be reloaded before release
                                        if (img_bad) begin
                                            o_err[ERR_CSUM] <= 1'b1;
                                        end else begin
                                            o_start      <= 1'b1;
                                            o_setup      <= 1'b0;
                                            o_start_addr <= addr;
                                            state        <= ST_RUNNING;
                                        end
                                    end
                                endcase
                            end else begin
                                o_err[ERR_CSUM] <= 1'b1;
                                if (kind == K_LOAD) begin
                                    img_bad <= 1'b1;
                                end
                            end
                        end
                    end
`endif
                    ST_RUNNING: begin
                        if (accept && i_byte == BL_CMD_HALT) begin
                            o_setup <= 1'b1;
                            bcnt    <= '0;
                            state   <= ST_IDLE;
                        end
                    end
                    default: begin
                        bcnt  <= '0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_core_boot_loader.sv
// Self-checking bench for core_boot_loader with randomized byte gaps.
// Expected writes/preloads/releases come from command-level arithmetic.
module tb_core_boot_loader;

    localparam int TO = 40;

    typedef logic [7:0] bq_t[$];

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        rdy;
    } iw_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } rw_t;

    typedef struct packed {
        logic [31:0] a;
        logic        setup;
    } st_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_byte = '0;
    logic        i_byte_valid = 1'b0;
    logic        o_byte_ready;
    logic [31:0] o_inst_mem_addr;
    logic [31:0] o_inst_mem_data;
    logic        o_inst_we;
    logic [4:0]  o_load_reg_addr;
    logic [31:0] o_load_reg_data;
    logic        o_reg_we;
    logic        o_setup;
    logic [31:0] o_start_addr;
    logic        o_start;
    logic [2:0]  o_err;

    int errors = 0;
    int checks = 0;

    iw_t iw_q[$];
    rw_t rw_q[$];
    st_t st_q[$];

    always #5 clk = ~clk;

    core_boot_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_byte          (i_byte),
        .i_byte_valid    (i_byte_valid),
        .o_byte_ready    (o_byte_ready),
        .o_inst_mem_addr (o_inst_mem_addr),
        .o_inst_mem_data (o_inst_mem_data),
        .o_inst_we       (o_inst_we),
        .o_load_reg_addr (o_load_reg_addr),
        .o_load_reg_data (o_load_reg_data),
        .o_reg_we        (o_reg_we),
        .o_setup         (o_setup),
        .o_start_addr    (o_start_addr),
        .o_start         (o_start),
        .o_err           (o_err)
    );

    always @(negedge clk) begin
        if (o_inst_we) iw_q.push_back('{o_inst_mem_addr, o_inst_mem_data, o_byte_ready});
        if (o_reg_we)  rw_q.push_back('{o_load_reg_addr, o_load_reg_data});
        if (o_start)   st_q.push_back('{o_start_addr, o_setup});
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q;
        iw_q.delete();
        rw_q.delete();
        st_q.delete();
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        i_byte_valid = 1'b0;
        idx_dummy();
        idle(3);
        rst = 1'b0;
        clear_q();
    endtask

    task automatic idx_dummy;
        i_byte = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int tries;
        idle($urandom_range(0, 3));
        i_byte = b;
        i_byte_valid = 1'b1;
        tries = 0;
        while (!o_byte_ready && tries < 10) begin
            @(negedge clk);
            tries++;
        end
        checks++;
        if (tries >= 10) begin
            errors++;
            $display("FAIL handshake: byte %h not accepted within 10 cycles", b);
        end
        @(negedge clk);
        i_byte_valid = 1'b0;
    endtask

    task automatic send_cmd(input bq_t q);
        logic [7:0] s;
        s = 8'h00;
        foreach (q[i]) begin
            send_byte(q[i]);
            s = s + q[i];
        end
`ifdef CORE_BOOT_LOADER_CHECKSUM_EN
        send_byte(8'h00 - s);
`endif
    endtask

    task automatic test_reset;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({o_setup, o_err, o_byte_ready, o_inst_we, o_reg_we, o_start} !== 8'b1_000_1_000 ||
                {o_inst_mem_addr, o_inst_mem_data, o_load_reg_addr, o_load_reg_data, o_start_addr} !== '0) begin
                errors++;
                $display("FAIL reset cyc %0d: setup=%b err=%b rdy=%b we=%b%b%b", c,
                         o_setup, o_err, o_byte_ready, o_inst_we, o_reg_we, o_start);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load_vector;
        bq_t q;
        iw_t exp [2];
        clear_q();
        q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00,
              8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        exp[0] = '{32'h0000_1000, 32'h0000_0013, 1'b0};
        exp[1] = '{32'h0000_1004, 32'h0010_0093, 1'b0};
        send_cmd(q);
        idle(4);
        checks++;
        if (iw_q.size() != 2) begin
            errors++;
            $display("FAIL load_vec count: got %0d want 2", iw_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (iw_q[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL load_vec w%0d: got a=%h d=%h rdy=%b want a=%h d=%h rdy=0",
                             i, iw_q[i].a, iw_q[i].d, iw_q[i].rdy, exp[i].a, exp[i].d);
                end
            end
        end
    endtask

    task automatic test_load_random;
        for (int t = 0; t < 5; t++) begin
            bq_t q;
            logic [31:0] base;
            logic [31:0] w [$];
            int n;
            clear_q();
            base = (t == 0) ? 32'hFFFF_FFFE : $urandom;
            n    = (t == 1) ? 0 : $urandom_range(1, 4);
            q.push_back(8'hA5);
            for (int k = 0; k < 4; k++) q.push_back(base[8*k +: 8]);
            q.push_back(8'(n));
            q.push_back(8'(n >> 8));
            for (int i = 0; i < n; i++) begin
                logic [31:0] v;
                v = $urandom;
                w.push_back(v);
                for (int k = 0; k < 4; k++) q.push_back(v[8*k +: 8]);
            end
            send_cmd(q);
            idle(4);
            checks++;
            if (iw_q.size() != n) begin
                errors++;
                $display("FAIL load_rnd%0d count: got %0d want %0d", t, iw_q.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    logic [31:0] ea;
                    ea = (base - (base % 4)) + 32'(4 * i);
                    checks++;
                    if (iw_q[i].a !== ea || iw_q[i].d !== w[i] || iw_q[i].rdy !== 1'b0) begin
                        errors++;
                        $display("FAIL load_rnd%0d w%0d: got a=%h d=%h want a=%h d=%h",
                                 t, i, iw_q[i].a, iw_q[i].d, ea, w[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reg;
        for (int t = 0; t < 4; t++) begin
            bq_t q;
            logic [7:0]  ib;
            logic [31:0] v;
            clear_q();
            ib = (t == 0) ? 8'h25 : 8'($urandom);
            v  = (t == 0) ? 32'hDEAD_BEEF : $urandom;
            q.push_back(8'h5A);
            q.push_back(ib);
            for (int k = 0; k < 4; k++) q.push_back(v[8*k +: 8]);
            send_cmd(q);
            idle(3);
            checks++;
            if (rw_q.size() != 1 || rw_q[0].a !== 5'(ib % 32) || rw_q[0].d !== v) begin
                errors++;
                $display("FAIL reg%0d: n=%0d got idx=%0d d=%h want idx=%0d d=%h",
                         t, rw_q.size(), rw_q.size() ? rw_q[0].a : 5'd0,
                         rw_q.size() ? rw_q[0].d : 32'd0, ib % 32, v);
            end
        end
    endtask

    task automatic test_run;
        for (int t = 0; t < 2; t++) begin
            bq_t q;
            logic [31:0] a;
            clear_q();
            a = (t == 0) ? 32'h0000_1000 : ($urandom | 32'h3);
            q.push_back(8'hC3);
            for (int k = 0; k < 4; k++) q.push_back(a[8*k +: 8]);
            send_cmd(q);
            idle(2);
            checks++;
            if (st_q.size() != 1 || st_q[0].a !== a - (a % 4) || st_q[0].setup !== 1'b0) begin
                errors++;
                $display("FAIL run%0d start: n=%0d got a=%h setup=%b want a=%h setup=0",
                         t, st_q.size(), st_q.size() ? st_q[0].a : 32'd0,
                         st_q.size() ? st_q[0].setup : 1'b1, a - (a % 4));
            end
            send_byte(8'h11);
            send_byte(8'hA5);
            idle(3);
            checks++;
            if (o_setup !== 1'b0 || o_err !== 3'b000 || o_byte_ready !== 1'b1 ||
                iw_q.size() != 0 || rw_q.size() != 0 || st_q.size() != 1) begin
                errors++;
                $display("FAIL run%0d ignore: setup=%b err=%b rdy=%b want setup=0 err=000 rdy=1",
                         t, o_setup, o_err, o_byte_ready);
            end
            send_byte(8'hFF);
            idle(1);
            checks++;
            if (o_setup !== 1'b1) begin
                errors++;
                $display("FAIL run%0d halt: setup=%b want 1", t, o_setup);
            end
        end
    endtask

    task automatic test_errors;
        bq_t q;
        do_reset();
        send_byte(8'h77);
        idle(2);
        checks++;
        if (o_err !== 3'b001) begin
            errors++;
            $display("FAIL err_cmd: got %b want 001", o_err);
        end
        send_byte(8'hA5);
        send_byte(8'h00);
        idle(TO + 5);
        checks++;
        if (o_err !== 3'b011) begin
            errors++;
            $display("FAIL err_timeout: got %b want 011", o_err);
        end
        clear_q();
        q = '{8'h5A, 8'h03, 8'h78, 8'h56, 8'h34, 8'h12};
        send_cmd(q);
        idle(3);
        checks++;
        if (rw_q.size() != 1 || rw_q[0].a !== 5'd3 || rw_q[0].d !== 32'h1234_5678) begin
            errors++;
            $display("FAIL after_timeout reg: n=%0d want one idx=3 d=12345678", rw_q.size());
        end
    endtask

    task automatic test_timeout_boundary;
        bq_t q;
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h40);
        send_byte(8'h00);
        idle(TO - 8);
        q = '{8'h00, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hCD, 8'hAB, 8'h89};
        foreach (q[i]) send_byte(q[i]);
`ifdef CORE_BOOT_LOADER_CHECKSUM_EN
        send_byte(8'h00 - (8'hA5 + 8'h40 + 8'h01 + 8'hEF + 8'hCD + 8'hAB + 8'h89));
`endif
        idle(3);
        checks++;
        if (iw_q.size() != 1 || iw_q[0].a !== 32'h0000_0040 ||
            iw_q[0].d !== 32'h89AB_CDEF || o_err !== 3'b000) begin
            errors++;
            $display("FAIL slow_load: n=%0d err=%b want one write a=40 d=89abcdef err=000",
                     iw_q.size(), o_err);
        end
    endtask

    task automatic test_reset_mid;
        bq_t q;
        do_reset();
        q = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
        foreach (q[i]) send_byte(q[i]);
        i_byte = 8'h44;
        i_byte_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        i_byte_valid = 1'b0;
        idle(1);
        rst = 1'b0;
        idle(5);
        checks++;
        if (iw_q.size() != 0 || o_setup !== 1'b1 || o_err !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid: writes=%0d setup=%b err=%b want 0/1/000",
                     iw_q.size(), o_setup, o_err);
        end
    endtask

`ifdef CORE_BOOT_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        bq_t q;
        do_reset();
        q = '{8'h5A, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        foreach (q[i]) send_byte(q[i]);
        idle(3);
        checks++;
        if (rw_q.size() != 0 || o_err !== 3'b100) begin
            errors++;
            $display("FAIL csum_bad: n=%0d err=%b want 0/100", rw_q.size(), o_err);
        end
        q[6] = 8'hA4;
        foreach (q[i]) send_byte(q[i]);
        idle(3);
        checks++;
        if (rw_q.size() != 1 || rw_q[0].a !== 5'd1 || rw_q[0].d !== 32'd1) begin
            errors++;
            $display("FAIL csum_good: n=%0d want one idx=1 d=1", rw_q.size());
        end
        do_reset();
        q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55};
        foreach (q[i]) send_byte(q[i]);
        q = '{8'hC3, 8'h00, 8'h10, 8'h00, 8'h00};
        send_cmd(q);
        idle(3);
        checks++;
        if (st_q.size() != 0 || o_setup !== 1'b1 || o_err !== 3'b100) begin
            errors++;
            $display("FAIL csum_img_bad: starts=%0d setup=%b err=%b", st_q.size(), o_setup, o_err);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_vector();
        test_load_random();
        test_reg();
        test_run();
        test_errors();
        test_timeout_boundary();
        test_reset_mid();
`ifdef CORE_BOOT_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_boot_loader.md
Name: core_boot_loader

Overview:
- Upstream setup stage for s_core. Consumes a byte stream from a host link (e.g. UART receiver) through a valid/ready handshake.
- Decodes load/run commands and drives the core's setup interface:
  - instruction-memory write address/data,
  - register preload address/data,
  - `setup` level and PC start address.
- Holds the core in setup from reset until a RUN command, and returns it to setup on HALT.

Parameters:
- `TIMEOUT_CYCLES`, 100000: inter-byte timeout inside a command; 0 disables the timeout.
- `CNT_W`, 16: width of the word-count field in LOAD; fixed at 16 for the 2-byte field.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `i_byte` in 8: incoming stream byte.
- `i_byte_valid` in 1: `i_byte` is valid.
- `o_byte_ready` out 1: loader accepts `i_byte` this cycle.
- `o_inst_mem_addr` out 32: instruction-memory write address (to `inst_mem_addr`).
- `o_inst_mem_data` out 32: instruction word (to `inst_mem_data`).
- `o_inst_we` out 1: one-cycle write strobe for addr/data.
- `o_load_reg_addr` out 5: register preload index (to `load_reg_addr`).
- `o_load_reg_data` out 32: register preload value (to `load_reg_data`).
- `o_reg_we` out 1: one-cycle register preload strobe.
- `o_setup` out 1: core setup level (to `setup`).
- `o_start_addr` out 32: PC start address (to `i_pc_instr_start_addr`).
- `o_start` out 1: one-cycle pulse when the core is released.
- `o_err` out 3: sticky errors. [0] unknown command, [1] timeout, [2] checksum.

Behaviour:
- **Reset values.** All data/address outputs 0. All strobes 0. `o_setup`=1, `o_err`=0, `o_byte_ready`=1, FSM=IDLE.
- **Handshake.** A byte is accepted when `i_byte_valid && o_byte_ready`. `o_byte_ready` is 0 only in the cycle of a WRITE strobe. Multi-byte fields are little-endian.
- **Commands (first byte, IDLE):**
  - 0xA5 LOAD: addr[4], count[2], then count words of 4 bytes each.
  - 0x5A REG: idx[1], data[4].
  - 0xC3 RUN: addr[4].
  - Any other byte: dropped, `o_err[0]` set, stay in IDLE.
- **States:** IDLE, L_ADDR, L_CNT, L_DATA, WRITE, R_IDX, R_DATA, G_ADDR, CHK (macro only), RUNNING.
- **Byte counter.** A 2-bit byte counter advances field collection and resets on every state change.
- **LOAD:**
  - Address bits [1:0] are forced to 00.
  - count=0: go to IDLE (or CHK) directly after L_CNT.
  - On acceptance of the 4th data byte, go to WRITE. Next cycle: `o_inst_we`=1 with the assembled word and current address.
  - After the strobe: address += 4 (wraps modulo 2^32), count -= 1. count reaches 0 → IDLE/CHK; otherwise → L_DATA.
- **REG:**
  - Index uses bits [4:0] of idx; bits [7:5] are ignored.
  - `o_reg_we` pulses one cycle after the last data byte. Index 0 is still issued.
- **RUN:**
  - `o_start_addr` is latched with bits [1:0] forced to 00.
  - `o_setup` falls in the same cycle that `o_start` pulses, one cycle after the last address byte.
  - FSM enters RUNNING.
- **RUNNING:**
  - `o_byte_ready`=1.
  - Byte 0xFF (HALT): `o_setup`=1 next cycle, FSM → IDLE.
  - All other bytes are dropped silently (no error).
- **Timeout.**
  - Applies in any state other than IDLE, WRITE and RUNNING.
  - The counter clears on every accepted byte.
  - Reaching `TIMEOUT_CYCLES` idle cycles: FSM → IDLE, `o_err[1]` set, partial command discarded.
  - Words already written by a LOAD stay written.
- **Reset mid-command.** Abandons the command immediately. No strobe is issued in the reset cycle or after it.
- **Error clearing.** `o_err` bits clear only on `rst`.

Optional Feature:
- Macro: `CORE_BOOT_LOADER_CHECKSUM_EN`.
- **Defined:** every command except HALT carries a trailing checksum byte, collected in state CHK.
  - The 8-bit sum of all command bytes including the checksum must equal 0x00.
  - REG: the preload strobe is deferred until after a passing CHK.
  - RUN: the release is deferred until after a passing CHK.
  - Mismatch sets `o_err[2]` and suppresses the REG or RUN action.
  - A LOAD mismatch sets an internal image-bad flag. While that flag is set, RUN commands are rejected (`o_err[2]` set) until a later LOAD passes.
- **Undefined:** no trailing byte, CHK state absent, `o_err[2]` tied 0.

Decomposition:
- Shared package/defines:
  - command byte constants `BL_CMD_LOAD` 0xA5, `BL_CMD_REG` 0x5A, `BL_CMD_RUN` 0xC3, `BL_CMD_HALT` 0xFF;
  - FSM state encodings;
  - `o_err` bit indices.
- One sub-module: `bl_word_assembler` — shifts 4 LE bytes into a 32-bit word and signals word_done on the 4th byte.

Test Plan:
- Reset released: `o_setup`=1, `o_err`=0, `o_byte_ready`=1, all strobes 0 for 10 cycles.
- Send A5 02 10 00 00 02 00 13 00 00 00 93 00 10 00 → `o_inst_we` pulses twice:
  - addr 0x00001000, data 0x00000013;
  - addr 0x00001004, data 0x00100093;
  - `o_byte_ready`=0 in each strobe cycle.
- Send 5A 25 EF BE AD DE → one `o_reg_we` with idx 5, data 0xDEADBEEF.
- Send C3 00 10 00 00 → `o_start` pulse and `o_setup`=0 in the same cycle, `o_start_addr`=0x00001000. Then 11 → ignored. Then FF → `o_setup`=1.
- Send 77 → `o_err`=3'b001. Send A5 00 then nothing for `TIMEOUT_CYCLES` → `o_err`=3'b011, FSM back in IDLE (next 5A command works).
- Macro defined: send 5A 01 01 00 00 00 00 (bad checksum) → no `o_reg_we`, `o_err[2]`=1. Resend with checksum A4 → `o_reg_we` with idx 1, data 1.
